// File: rtl/pc_go_handshake.sv
// Switch conditioner for the picoMIPS PC: sync, debounce, press/release handshake -> one-cycle go pulse.
// Define PC_GO_DEBOUNCE_EN to build the DEB_CYCLES debounce counter; undefined gives a counter-free fast-sim build.
module pc_go_handshake #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  input  logic wait_req,
  output logic go,
  output logic sw_level,
  output logic armed
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FIRE  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic       r_s1;
  logic       r_s2;
  logic       w_level;
  logic [1:0] r_state;
  logic [1:0] w_stateNext;
  logic       r_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sw_in;
      r_s2 <= r_s1;
    end
  end

`ifdef PC_GO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_swLevel;

  // Level flips only after DEB_CYCLES consecutive edges of disagreement with s2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_swLevel <= 1'b0;
    end else if (r_s2 == r_swLevel) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_swLevel <= r_s2;
      r_cnt     <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_level = r_swLevel;
`else
  // Without debounce the level is the second synchroniser flop itself, giving D = 0 timing.
  assign w_level = r_s2;
`endif

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (wait_req && !w_level) w_stateNext = ST_ARMED;
      ST_ARMED: begin
        if (!wait_req)    w_stateNext = ST_IDLE;
        else if (w_level) w_stateNext = ST_FIRE;
      end
      ST_FIRE:  w_stateNext = ST_HOLD;
      ST_HOLD:  if (!w_level) w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_go    <= (w_stateNext == ST_FIRE);
    end
  end

  assign go       = r_go;
  assign sw_level = w_level;
  assign armed    = (r_state == ST_ARMED);

endmodule

// File: tb/tb_pc_go_handshake.sv
// Self-checking bench for pc_go_handshake with a behavioural model of sync/debounce/handshake.
// Tracks the PC_GO_DEBOUNCE_EN build: D = DEB when defined, 0 otherwise.
module tb_pc_go_handshake;

  localparam int DEB = 4;
`ifdef PC_GO_DEBOUNCE_EN
  localparam int D = DEB;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw_in = 1'b0;
  logic wait_req = 1'b0;
  logic go;
  logic sw_level;
  logic armed;

  int nChecks = 0;
  int nFail = 0;
  int dutGoCount = 0;
  int modelGoCount = 0;

  // Model: sync pipeline, debounced level with run length, and handshake flags.
  logic ms1 = 1'b0, ms2 = 1'b0, mLevel = 1'b0;
  int   mRun = 0;
  logic mReady = 1'b0, mFire = 1'b0, mLatched = 1'b0;

  pc_go_handshake #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .wait_req(wait_req),
    .go(go), .sw_level(sw_level), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    ms1 = 1'b0; ms2 = 1'b0; mLevel = 1'b0; mRun = 0;
    mReady = 1'b0; mFire = 1'b0; mLatched = 1'b0;
  endtask

  // Drive inputs, take one rising edge, advance the model, settle 1 time unit past the edge.
  task automatic tick(input logic swv, input logic wrv);
    logic o1, o2, ol;
    sw_in = swv;
    wait_req = wrv;
    @(posedge clk);
    o1 = ms1; o2 = ms2; ol = mLevel;
    if (!reset) begin
      modelReset();
    end else begin
      ms1 = swv;
      ms2 = o1;
      if (D == 0) mLevel = o1;
      else if (o2 == ol) mRun = 0;
      else if (mRun + 1 == D) begin mLevel = o2; mRun = 0; end
      else mRun++;
      if (mFire) begin
        mFire = 1'b0; mLatched = 1'b1;
      end else if (mLatched) begin
        if (!ol) mLatched = 1'b0;
      end else if (mReady) begin
        if (!wrv) mReady = 1'b0;
        else if (ol) begin mReady = 1'b0; mFire = 1'b1; end
      end else if (wrv && !ol) begin
        mReady = 1'b1;
      end
    end
    #1;
    if (go === 1'b1) dutGoCount++;
    if (mFire) modelGoCount++;
  endtask

  task automatic test_reset();
    nChecks++;
    if (go !== 1'b0 || armed !== 1'b0 || sw_level !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_initial: go=%b armed=%b sw_level=%b required 0 0 0", go, armed, sw_level);
    end
    for (int i = 0; i < 12; i++) begin
      tick(i[0], i[1]);
      nChecks++;
      if (go !== 1'b0 || armed !== 1'b0 || sw_level !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL reset_held: go=%b armed=%b sw_level=%b required 0 0 0", go, armed, sw_level);
      end
    end
    tick(1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < D + 6; i++) begin
      tick(1'b0, 1'b0);
      nChecks++;
      if (go !== 1'b0 || armed !== 1'b0 || sw_level !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL reset_release_idle: go=%b armed=%b sw_level=%b required 0 0 0", go, armed, sw_level);
      end
    end
  endtask

  task automatic test_clean_press();
    int g0;
    tick(1'b0, 1'b1);
    nChecks++;
    if (armed !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL clean_armed: armed=%b required 1", armed);
    end
    g0 = dutGoCount;
    for (int k = 0; k < D + 6; k++) begin
      tick(1'b1, 1'b1);
      nChecks++;
      if (go !== (k == D + 2) || go !== mFire || armed !== mReady || sw_level !== mLevel) begin
        nFail++;
        $display("[TB] FAIL clean_press k=%0d: go=%b armed=%b sw_level=%b required %b %b %b",
                 k, go, armed, sw_level, (k == D + 2), mReady, mLevel);
      end
    end
    nChecks++;
    if (dutGoCount - g0 !== 1) begin
      nFail++;
      $display("[TB] FAIL clean_pulse_count: got=%0d required 1", dutGoCount - g0);
    end
    for (int k = 0; k < D + 8; k++) begin
      tick(1'b0, 1'b1);
      nChecks++;
      if (go !== mFire || armed !== mReady || sw_level !== mLevel) begin
        nFail++;
        $display("[TB] FAIL clean_release k=%0d: go=%b armed=%b sw_level=%b required %b %b %b",
                 k, go, armed, sw_level, mFire, mReady, mLevel);
      end
    end
    nChecks++;
    if (armed !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL clean_rearm: armed=%b required 1", armed);
    end
  endtask

  task automatic test_bounce();
    int g0;
    int len;
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j <= len; j++) begin
        tick(j < len, 1'b1);
        nChecks++;
        if (go !== mFire || armed !== mReady || sw_level !== mLevel) begin
          nFail++;
          $display("[TB] FAIL bounce p=%0d j=%0d: go=%b armed=%b sw_level=%b required %b %b %b",
                   p, j, go, armed, sw_level, mFire, mReady, mLevel);
        end
      end
    end
    for (int j = 0; j < D + 6; j++) tick(1'b0, 1'b1);
    nChecks++;
    if (dutGoCount !== modelGoCount || armed !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL bounce_totals: go_count=%0d armed=%b required %0d 1", dutGoCount, armed, modelGoCount);
    end
    g0 = dutGoCount;
    for (int j = 0; j < D + 6; j++) begin
      tick(1'b1, 1'b1);
      nChecks++;
      if (go !== mFire || armed !== mReady || sw_level !== mLevel) begin
        nFail++;
        $display("[TB] FAIL bounce_hold j=%0d: go=%b armed=%b sw_level=%b required %b %b %b",
                 j, go, armed, sw_level, mFire, mReady, mLevel);
      end
    end
    for (int j = 0; j < D + 6; j++) tick(1'b0, 1'b1);
    nChecks++;
    if (dutGoCount - g0 !== 1) begin
      nFail++;
      $display("[TB] FAIL bounce_hold_count: got=%0d required 1", dutGoCount - g0);
    end
  endtask

  task automatic test_held_switch();
    int g0;
    for (int j = 0; j < D + 4; j++) tick(1'b1, 1'b0);
    g0 = dutGoCount;
    for (int j = 0; j < 1000; j++) begin
      tick(1'b1, 1'b1);
      if (j % 100 == 7) begin
        nChecks++;
        if (go !== 1'b0 || armed !== 1'b0 || sw_level !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL held_idle j=%0d: go=%b armed=%b sw_level=%b required 0 0 1", j, go, armed, sw_level);
        end
      end
    end
    nChecks++;
    if (dutGoCount !== g0) begin
      nFail++;
      $display("[TB] FAIL held_no_go: got=%0d required 0", dutGoCount - g0);
    end
    for (int j = 0; j < D + 6; j++) tick(1'b0, 1'b1);
    nChecks++;
    if (armed !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL held_rearm: armed=%b required 1", armed);
    end
    for (int j = 0; j < 1000; j++) begin
      tick(1'b1, 1'b1);
      if (go !== mFire || armed !== mReady) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL long_hold j=%0d: go=%b armed=%b required %b %b", j, go, armed, mFire, mReady);
      end
    end
    nChecks++;
    if (dutGoCount - g0 !== 1) begin
      nFail++;
      $display("[TB] FAIL long_hold_count: got=%0d required 1", dutGoCount - g0);
    end
    for (int j = 0; j < D + 6; j++) tick(1'b0, 1'b1);
  endtask

  task automatic test_withdrawn();
    int g0;
    g0 = dutGoCount;
    for (int k = 0; k < D + 2; k++) tick(1'b1, 1'b1);
    nChecks++;
    if (armed !== 1'b1 || sw_level !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL withdraw_setup: armed=%b sw_level=%b required 1 1", armed, sw_level);
    end
    tick(1'b1, 1'b0);
    nChecks++;
    if (go !== 1'b0 || armed !== 1'b0 || mReady !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL withdraw_edge: go=%b armed=%b required 0 0", go, armed);
    end
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    for (int k = 0; k < D + 4; k++) tick(1'b0, 1'b0);
    nChecks++;
    if (dutGoCount !== g0 || armed !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL withdraw_no_go: go_count=%0d armed=%b required 0 0", dutGoCount - g0, armed);
    end
  endtask

  task automatic test_reset_mid();
    int g0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1);
    #2;
    reset = 1'b0;
    sw_in = 1'b0;
    #1;
    modelReset();
    nChecks++;
    if (go !== 1'b0 || armed !== 1'b0 || sw_level !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_async: go=%b armed=%b sw_level=%b required 0 0 0", go, armed, sw_level);
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    reset = 1'b1;
    g0 = dutGoCount;
    for (int k = 0; k < D + 8; k++) begin
      tick(1'b0, 1'b1);
      nChecks++;
      if (go !== 1'b0 || armed !== mReady || sw_level !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL reset_after k=%0d: go=%b armed=%b sw_level=%b required 0 %b 0",
                 k, go, armed, sw_level, mReady);
      end
    end
    for (int k = 0; k < D + 6; k++) tick(1'b1, 1'b1);
    for (int k = 0; k < D + 6; k++) tick(1'b0, 1'b1);
    nChecks++;
    if (dutGoCount - g0 !== 1 || dutGoCount !== modelGoCount) begin
      nFail++;
      $display("[TB] FAIL reset_fresh_press: got=%0d total=%0d required 1 %0d",
               dutGoCount - g0, dutGoCount, modelGoCount);
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_clean_press();
    test_bounce();
    test_held_switch();
    test_withdrawn();
    test_reset_mid();
    nChecks++;
    if (dutGoCount !== modelGoCount) begin
      nFail++;
      $display("[TB] FAIL total_pulses: got=%0d required %0d", dutGoCount, modelGoCount);
    end
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
